// File: rtl/adder_tree_packer_pkg.sv
// Shared sizing for adder_tree, its packer and their benches, plus slot placement.
package adder_tree_packer_pkg;

    localparam int DEF_NUM      = 18;
    localparam int DEF_LEN      = 16;
    localparam int DEF_TREE_LAT = 2;
    localparam int DEF_CNT_W    = $clog2(DEF_NUM + 1);

    // Bit offset of the least significant bit of slot k; slot 0 sits at the top.
    function automatic int unsigned slot_lsb(input int unsigned k,
                                             input int unsigned num,
                                             input int unsigned len);
        return (num - 1 - k) * len;
    endfunction

endpackage

// File: rtl/adder_tree_packer_if.sv
// Sample stream in, packed group out, and the sum tag that follows the adder tree.
interface adder_tree_packer_if
    import adder_tree_packer_pkg::*;
#(
    parameter int NUM   = DEF_NUM,
    parameter int LEN   = DEF_LEN,
    parameter int CNT_W = $clog2(NUM + 1)
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic signed [LEN-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [NUM*LEN-1:0]    out_vec;
    logic [CNT_W-1:0]      out_count;
    logic                  sum_valid;
    logic [CNT_W-1:0]      sum_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_vec, out_count, sum_valid, sum_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_vec, out_count, sum_valid, sum_count
    );

endinterface

// File: rtl/adder_tree_packer_valid_delay_line.sv
// Fixed-depth shift register that re-times a tag to line up with a pipelined result.
module valid_delay_line #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    // Shift the tag one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/adder_tree_packer.sv
// Packs a serial sample stream into NUM-wide groups for adder_tree and tags its sum.
module adder_tree_packer
    import adder_tree_packer_pkg::*;
#(
    parameter int NUM      = DEF_NUM,
    parameter int LEN      = DEF_LEN,
    parameter int TREE_LAT = DEF_TREE_LAT,
    parameter int CNT_W    = $clog2(NUM + 1)
) (
    input logic               clk,
    input logic               rst_n,
    adder_tree_packer_if.slave bus
);

    logic [NUM*LEN-1:0] coll_buf;
    logic [CNT_W-1:0]   cnt;
    logic               full;

    logic [NUM*LEN-1:0] buf_base;
    logic [NUM*LEN-1:0] buf_next;
    logic [CNT_W-1:0]   cnt_base;
    logic [CNT_W-1:0]   cnt_next;
    logic               full_next;

    logic               out_valid;
    logic [NUM*LEN-1:0] out_vec;
    logic [CNT_W-1:0]   out_count;

    logic               accept;
    logic               xfer;
    logic               fire;
    logic               in_ready;
    logic [CNT_W:0]     tag_q;

    assign xfer     = full & (!out_valid | bus.out_ready);
    assign in_ready = !full | xfer;
    assign accept   = bus.in_valid & in_ready;
    assign fire     = out_valid & bus.out_ready;

    // Next collect state: a transfer empties the buffer first, so a sample
    // accepted on the same edge lands in slot 0 of a clean group.
    always_comb begin
        buf_base  = xfer ? '0 : coll_buf;
        cnt_base  = xfer ? '0 : cnt;
        buf_next  = buf_base;
        cnt_next  = cnt_base;
        full_next = full & !xfer;
        if (accept) begin
            for (int k = 0; k < NUM; k++) begin
                if (cnt_base == CNT_W'(k)) begin
                    buf_next[slot_lsb(k, NUM, LEN) +: LEN] = bus.in_data;
                end
            end
            cnt_next  = cnt_base + CNT_W'(1);
            full_next = (cnt_base == CNT_W'(NUM - 1)) | bus.in_last;
        end
    end

    // Collect buffer registers; cnt doubles as the real-sample count of the group.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll_buf <= '0;
            cnt      <= '0;
            full     <= 1'b0;
        end else begin
            coll_buf <= buf_next;
            cnt      <= cnt_next;
            full     <= full_next;
        end
    end

    // Output holding register; the vector stays put after a fire until the next transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_count <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_vec   <= coll_buf;
            out_count <= cnt;
        end else if (fire) begin
            out_valid <= 1'b0;
        end
    end

    valid_delay_line #(
        .DEPTH (TREE_LAT),
        .W     (CNT_W + 1)
    ) u_tag_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({fire, out_count}),
        .q     (tag_q)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_vec   = out_vec;
    assign bus.out_count = out_count;
    assign bus.sum_valid = tag_q[CNT_W];
    assign bus.sum_count = tag_q[CNT_W-1:0];

endmodule

// File: tb/tb_adder_tree_packer.sv
// Bench for adder_tree_packer with a queue-based group model and a behavioural adder tree.
module tb_adder_tree_packer;
    import adder_tree_packer_pkg::*;

    localparam int NUM      = DEF_NUM;
    localparam int LEN      = DEF_LEN;
    localparam int TREE_LAT = DEF_TREE_LAT;
    localparam int CNT_W    = DEF_CNT_W;
    localparam int VW       = NUM * LEN;

    logic clk;
    logic rst_n;

    adder_tree_packer_if #(.NUM(NUM), .LEN(LEN), .CNT_W(CNT_W)) bus ();

    adder_tree_packer #(
        .NUM      (NUM),
        .LEN      (LEN),
        .TREE_LAT (TREE_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int stall_cnt = 0;

    logic [LEN-1:0]  cur_grp [$];
    logic [VW-1:0]   exp_vec [$];
    int              exp_cnt [$];
    int              exp_sum [$];
    int              pend_cyc [$];
    int              pend_cnt [$];
    int              pend_sum [$];
    int              fire_cycles [$];
    logic            hold_prev = 1'b0;
    logic [VW-1:0]   prev_vec;
    logic [CNT_W-1:0] prev_cnt;
    int              tree_pipe [TREE_LAT];

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int treeSum(input logic [VW-1:0] v);
        int s = 0;
        for (int k = 0; k < NUM; k++) s += int'($signed(v[k*LEN +: LEN]));
        return s;
    endfunction

    // Stand-in for adder_tree: sum of all slots, TREE_LAT registers deep
    always @(posedge clk) begin
        tree_pipe[0] <= treeSum(bus.out_vec);
        for (int i = 1; i < TREE_LAT; i++) tree_pipe[i] <= tree_pipe[i-1];
    end

    // Reference model: samples gather into groups; groups must leave in order,
    // and each fire must be echoed by sum_valid TREE_LAT cycles later
    always @(negedge clk) begin
        logic exp_sv;
        logic [VW-1:0] v;
        int s;
        cycle++;
        exp_sv = (pend_cyc.size() > 0) && (pend_cyc[0] == cycle - TREE_LAT);
        if (exp_sv || bus.sum_valid) begin
            checkOutput("sum_valid", VW'(bus.sum_valid), VW'(exp_sv));
            if (exp_sv) begin
                checkOutput("sum_count", VW'(bus.sum_count), VW'(pend_cnt[0]));
                checkOutput("tree_sum", VW'(tree_pipe[TREE_LAT-1]), VW'(pend_sum[0]));
                void'(pend_cyc.pop_front());
                void'(pend_cnt.pop_front());
                void'(pend_sum.pop_front());
            end
        end
        if (!rst_n) begin
            cur_grp.delete(); exp_vec.delete(); exp_cnt.delete(); exp_sum.delete();
            pend_cyc.delete(); pend_cnt.delete(); pend_sum.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checkOutput("hold_valid", VW'(bus.out_valid), VW'(1));
                checkOutput("hold_vec", bus.out_vec, prev_vec);
                checkOutput("hold_count", VW'(bus.out_count), VW'(prev_cnt));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_vec.size() == 0) begin
                    checkOutput("unexpected_fire", VW'(1), VW'(0));
                end else begin
                    checkOutput("out_vec", bus.out_vec, exp_vec[0]);
                    checkOutput("out_count", VW'(bus.out_count), VW'(exp_cnt[0]));
                    pend_cyc.push_back(cycle);
                    pend_cnt.push_back(exp_cnt[0]);
                    pend_sum.push_back(exp_sum[0]);
                    void'(exp_vec.pop_front());
                    void'(exp_cnt.pop_front());
                    void'(exp_sum.pop_front());
                end
                fire_cycles.push_back(cycle);
            end
            if (bus.in_valid && bus.in_ready) begin
                cur_grp.push_back(bus.in_data);
                if (cur_grp.size() == NUM || bus.in_last) begin
                    v = '0;
                    s = 0;
                    for (int k = 0; k < cur_grp.size(); k++) begin
                        v[(NUM-k)*LEN-1 -: LEN] = cur_grp[k];
                        s += int'($signed(cur_grp[k]));
                    end
                    exp_vec.push_back(v);
                    exp_cnt.push_back(cur_grp.size());
                    exp_sum.push_back(s);
                    cur_grp.delete();
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            prev_vec  = bus.out_vec;
            prev_cnt  = bus.out_count;
        end
    end

    // Hard stop if something wedges the run
    always @(posedge clk) begin
        if (cycle > 20000) begin
            $display("[TB] FAIL watchdog: got cycle %0d expected below 20000", cycle);
            $fatal(1, "[TB] watchdog");
        end
    end

    // Present one sample and hold it until accepted (bounded); leaves in_valid high
    task automatic applyStimulus(input logic [LEN-1:0] d, input logic last);
        logic ok;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) return;
            stall_cnt++;
        end
        checkOutput("accept_timeout", VW'(0), VW'(1));
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitOutValid(input string tag);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.out_valid) return;
        end
        checkOutput(tag, VW'(0), VW'(1));
    endtask

    initial begin
        int accepted;
        logic rdy;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", VW'(bus.out_valid), VW'(0));
        checkOutput("rst_out_vec", bus.out_vec, VW'(0));
        checkOutput("rst_out_count", VW'(bus.out_count), VW'(0));
        checkOutput("rst_sum_valid", VW'(bus.sum_valid), VW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", VW'(bus.in_ready), VW'(1));
        @(posedge clk);
        #1;

        // Eighteen ones with exact output and sum timing
        bus.out_ready = 1'b1;
        for (int i = 0; i < NUM; i++) applyStimulus(16'h0001, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lat_not_yet", VW'(bus.out_valid), VW'(0));
        @(negedge clk);
        checkOutput("lat_valid", VW'(bus.out_valid), VW'(1));
        checkOutput("ones_count", VW'(bus.out_count), VW'(18));
        checkOutput("ones_vec", bus.out_vec, {NUM{16'h0001}});
        @(negedge clk);
        checkOutput("sum_early", VW'(bus.sum_valid), VW'(0));
        @(negedge clk);
        checkOutput("sum_on_time", VW'(bus.sum_valid), VW'(1));
        checkOutput("sum_value", VW'(tree_pipe[TREE_LAT-1]), VW'(18));
        @(posedge clk);
        #1;

        // Ascending values: first in MS slot, last in LS slot
        for (int i = 1; i <= NUM; i++) applyStimulus(LEN'(i), 1'b0);
        bus.in_valid = 1'b0;
        waitOutValid("seq_wait");
        checkOutput("seq_ms_slot", VW'(bus.out_vec[VW-1 -: LEN]), VW'(1));
        checkOutput("seq_ls_slot", VW'(bus.out_vec[LEN-1:0]), VW'(18));
        idle(2);

        // Minus one passes through unchanged
        for (int i = 0; i < NUM; i++) applyStimulus(16'hFFFF, 1'b0);
        idle(5);

        // Short group closed by in_last, then a full group behind it
        for (int i = 0; i < 5; i++) applyStimulus(LEN'($urandom), i == 4);
        bus.in_valid = 1'b0;
        waitOutValid("short_wait");
        checkOutput("short_count", VW'(bus.out_count), VW'(5));
        idle(2);
        for (int i = 0; i < NUM; i++) applyStimulus(LEN'($urandom), 1'b0);
        idle(5);

        // Back-pressure: two groups stack up, then drain on consecutive handshakes
        bus.out_ready = 1'b0;
        accepted = 0;
        bus.in_valid = 1'b1;
        bus.in_last = 1'b0;
        bus.in_data = LEN'($urandom);
        repeat (40) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                accepted++;
                bus.in_data = LEN'($urandom);
            end
        end
        checkOutput("stall_accepts", VW'(accepted), VW'(36));
        checkOutput("stall_ready_low", VW'(bus.in_ready), VW'(0));
        fire_cycles.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("resume_ready", VW'(bus.in_ready), VW'(1));
        @(posedge clk);
        #1;
        applyStimulus(LEN'($urandom), 1'b0);
        applyStimulus(LEN'($urandom), 1'b1);
        idle(6);
        if (fire_cycles.size() < 2)
            checkOutput("two_fires", VW'(fire_cycles.size()), VW'(2));
        else
            checkOutput("fires_back_to_back", VW'(fire_cycles[1] - fire_cycles[0]), VW'(1));

        // Streaming three groups: no bubbles, one group every NUM cycles
        stall_cnt = 0;
        fire_cycles.delete();
        for (int i = 0; i < 3 * NUM; i++) applyStimulus(LEN'($urandom), 1'b0);
        idle(5);
        checkOutput("stream_stalls", VW'(stall_cnt), VW'(0));
        checkOutput("stream_fires", VW'(fire_cycles.size()), VW'(3));
        if (fire_cycles.size() == 3) begin
            checkOutput("stream_gap1", VW'(fire_cycles[1] - fire_cycles[0]), VW'(NUM));
            checkOutput("stream_gap2", VW'(fire_cycles[2] - fire_cycles[1]), VW'(NUM));
        end

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_last   = ($urandom_range(0, 9) == 0);
            bus.in_data   = LEN'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        applyStimulus(LEN'($urandom), 1'b1);
        idle(10);

        // Reset with a group half-collected and a sum still in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < NUM + 10; i++) applyStimulus(LEN'($urandom), 1'b0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        accepted = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid || bus.sum_valid) accepted++;
        end
        checkOutput("post_reset_quiet", VW'(accepted), VW'(0));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NUM; i++) applyStimulus(LEN'($urandom), 1'b0);
        bus.in_valid = 1'b0;
        waitOutValid("clean_wait");
        checkOutput("clean_count", VW'(bus.out_count), VW'(18));
        idle(8);

        checkOutput("drain_groups", VW'(exp_vec.size()), VW'(0));
        checkOutput("drain_sums", VW'(pend_cyc.size()), VW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_tree_packer.md
Name: adder_tree_packer

Overview:
Upstream feeder for adder_tree. Collects a serial stream of signed LEN-bit samples (valid/ready) into groups of NUM and presents each group as one packed NUM*LEN vector on a valid/ready output, held stable for adder_tree to consume. Short groups are closed early with in_last and zero-padded. A delay line tags adder_tree's sum with a valid and the real sample count, TREE_LAT cycles after each output handshake.

Parameters:
NUM, 18, samples per group (adder_tree fan-in)
LEN, 16, sample width in bits, two's complement
TREE_LAT, 2, adder_tree pipeline latency in cycles, must be >= 1
CNT_W, $clog2(NUM+1), width of the count fields

Ports:
clk  in  1  clock; all logic on its rising edge
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  upstream sample valid
in_ready  out  1  packer can accept a sample
in_data  in  LEN  signed sample
in_last  in  1  accepted sample closes the current group early
out_valid  out  1  packed group valid
out_ready  in  1  downstream accepts the group
out_vec  out  NUM*LEN  packed group, drives adder_tree in
out_count  out  CW  number of real (non-pad) samples in out_vec, 1..NUM
sum_valid  out  1  adder_tree sum corresponds to a fired group
sum_count  out  CW  out_count of that group

Behaviour:
- Reset: rst_n sampled low at a clk edge clears everything. out_valid=0, out_vec=0, out_count=0, sum_valid=0, sum_count=0, collect buffer=0, cnt=0, full=0. in_ready is 1 in the first cycle after reset is released.
- Reset mid-group or mid-hold discards the partial group, the held group and all in-flight delay-line entries. No sum_valid follows.
- Accept = in_valid & in_ready. Fire = out_valid & out_ready.
- Slot order: the k-th accepted sample of a group (k=0..NUM-1) goes to out_vec[(NUM-k)*LEN-1 -: LEN]. The first sample occupies the MS slot and the last occupies the LS slot.
- Collect: write slot cnt, then cnt++. Set full when the accepted sample has cnt==NUM-1 or has in_last=1. The group's count is recorded as cnt+1.
- in_last is ignored unless the sample is accepted. in_last on slot NUM-1 is the same as a normal full group.
- Transfer: xfer = full & (!out_valid | out_ready). On xfer the collect buffer and count are copied to out_vec/out_count, out_valid is set, and the collect buffer, cnt and full are cleared in the same edge.
- Early-closed groups therefore carry zeros in all unwritten slots.
- in_ready = !full | xfer (combinational).
- Simultaneous accept and xfer: the new sample lands in slot 0 of the freshly cleared buffer. Full throughput is one group per NUM cycles.
- Latency: the completing sample accepted at edge E sets full at E; out_valid is high after E+1 if the output is free.
- Fire with no pending xfer: out_valid is cleared. out_vec is held unchanged (not cleared) until the next xfer.
- out_vec and out_count are stable while out_valid=1 and out_ready=0.
- Delay line: TREE_LAT-deep shift of {fire, out_count}. sum_valid/sum_count equal the values at fire, delayed by TREE_LAT cycles.
- No arithmetic on the samples; data passes through bit-exact.

Decomposition:
- Shared package holds the NUM, LEN and CNT_W defaults so adder_tree, the packer and the benches agree, plus the function computing the slot bit offset.
- One sub-module: valid_delay_line (parameters DEPTH and W, synchronous active-low reset), reused for sum_valid/sum_count tagging.

Test Plan:
- 18 samples of value 1, out_ready=1, packer connected to adder_tree (TREE_LAT=2) -> out_vec all slots 16'h0001, out_count=18. sum=18 with sum_valid=1, sum_count=18 exactly 2 cycles after fire.
- Samples 1..18 in order -> MS slot =1, LS slot =18. Values -1 (16'hFFFF) pass through bit-exact.
- 5 samples with in_last on the 5th -> out_count=5, slots 0..4 = the samples, slots 5..17 = 0. The next group starts at slot 0.
- out_ready held low, 40 samples offered continuously -> group 1 held stable, group 2 completes in the collect buffer, in_ready drops after 36 accepts. Raising out_ready gives two fires on consecutive handshakes, and accepts resume on the xfer cycle.
- Continuous in_valid with out_ready=1 for 3 groups -> no in_ready bubble; out_valid pulses every 18 cycles.
- rst_n low for 1 cycle after 10 samples of a group and during a pending sum -> no out_valid and no sum_valid. The next 18 samples form a clean group with out_count=18.
